// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_pkg
//  Description : Shared writeback types, derived widths and block defaults
//                for the functional-unit writeback collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int PREG_W    = 6;
    localparam int XLEN      = 32;
    localparam int FLAGS_W   = 4;

    // Common data bus payload: physical destination and result value.
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] dest;
        logic [XLEN-1:0]   result;
    } cdb_t;

    // Packet an FU hands to writeback; cdb sits in the low bits.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_dest;
        logic [FLAGS_W-1:0]   flags;
        cdb_t                 cdb;
    } rob_wb_t;

    // Register-file write request.
    typedef struct packed {
        cdb_t cdb;
        logic w_v;
    } reg_wb_t;

    localparam int ROB_WB_WIDTH  = $bits(rob_wb_t);
    localparam int REG_WB_WIDTH  = $bits(reg_wb_t);
    // Bit position of cdb.valid inside a packed rob_wb_t.
    localparam int CDB_VALID_BIT = $bits(cdb_t) - 1;

    localparam int WB_N_FU       = 4;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_SKID       = 2;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Single-source writeback FIFO with push/pop/flush, occupancy
//                count and a drop pulse for pushes that found no room.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i && (count != '0);
    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);
    // Flush discards the cycle's pushes, so they never count as drops.
    assign drop_o  = push_i && full && !do_pop && !flush_i;

    assign data_o  = mem[head];
    assign count_o = count;

    // Storage array: written at the tail, no reset needed on the payload.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem[tail] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Collects writeback packets from N_FU non-stallable execute
//                units into per-FU FIFOs and round-robin arbitrates them onto
//                a single registered ROB / register-file writeback port.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_FU       = WB_N_FU,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int SKID       = WB_SKID
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [N_FU*ROB_WB_WIDTH-1:0] fu_wb_i,
    output logic [ROB_WB_WIDTH-1:0]      rob_wb_o,
    output logic [REG_WB_WIDTH-1:0]      reg_wb_o,
    output logic [N_FU-1:0]              fu_stall_o,
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(N_FU);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ROB_WB_WIDTH-1:0] head_data [N_FU];
    logic [CNT_W-1:0]        count     [N_FU];
    logic [N_FU-1:0]         push;
    logic [N_FU-1:0]         pop;
    logic [N_FU-1:0]         drop;
    logic [N_FU-1:0]         nonempty;

    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        next_ptr;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_any;
    logic [PTR_W:0]          cand;

    rob_wb_t                 granted_pkt;
    rob_wb_t                 rob_q;
    reg_wb_t                 reg_wb;
    logic                    overflow;

    // Per-FU FIFO, push decode and stall hint.
    for (genvar i = 0; i < N_FU; i++) begin : g_fu
        assign push[i]     = fu_wb_i[i*ROB_WB_WIDTH + CDB_VALID_BIT];
        assign pop[i]      = grant_any && (grant_idx == PTR_W'(i));
        assign nonempty[i] = (count[i] != '0);
        // Raised while free space no longer covers the packets already in flight.
        assign fu_stall_o[i] = (FIFO_DEPTH - int'(count[i])) <= SKID;

        wb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ROB_WB_WIDTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .flush_i (flush_i),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .data_i  (fu_wb_i[i*ROB_WB_WIDTH +: ROB_WB_WIDTH]),
            .data_o  (head_data[i]),
            .count_o (count[i]),
            .drop_o  (drop[i])
        );
    end

    // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_FU; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_FU)) begin
                cand = cand - (PTR_W+1)'(N_FU);
            end
            if (!grant_any && nonempty[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    // Granted head with valid forced high, and the pointer past the winner.
    always_comb begin
        granted_pkt           = rob_wb_t'(head_data[grant_idx]);
        granted_pkt.cdb.valid = 1'b1;
        next_ptr              = (grant_idx == PTR_W'(N_FU - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Round-robin pointer: advances only when something was granted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr <= '0;
        end else if (flush_i) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= next_ptr;
        end
    end

    // Output register: winner's packet, or all-zero on idle / flush.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rob_q <= '0;
        end else if (flush_i || !grant_any) begin
            rob_q <= '0;
        end else begin
            rob_q <= granted_pkt;
        end
    end

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end
    end

    // Register-file view is a straight re-pack of the registered ROB packet.
    always_comb begin
        reg_wb.cdb = rob_q.cdb;
        reg_wb.w_v = rob_q.cdb.valid;
    end

    assign rob_wb_o   = rob_q;
    assign reg_wb_o   = reg_wb;
    assign overflow_o = overflow;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed self-checking bench for wb_arbiter (N_FU=4,
//                FIFO_DEPTH=4, SKID=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush;
    rob_wb_t                   fu_pkt [N];
    logic [N*ROB_WB_WIDTH-1:0] fu_wb;
    logic [ROB_WB_WIDTH-1:0]   rob_wb;
    logic [REG_WB_WIDTH-1:0]   reg_wb;
    logic [N-1:0]              stall;
    logic                      ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign fu_wb[g*ROB_WB_WIDTH +: ROB_WB_WIDTH] = fu_pkt[g];
    end

    wb_arbiter #(
        .N_FU       (N),
        .FIFO_DEPTH (4),
        .SKID       (2)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .flush_i    (flush),
        .fu_wb_i    (fu_wb),
        .rob_wb_o   (rob_wb),
        .reg_wb_o   (reg_wb),
        .fu_stall_o (stall),
        .overflow_o (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic rob_wb_t mk(input int rd, input int d, input int r);
        rob_wb_t p;
        p            = '0;
        p.rob_dest   = 5'(rd);
        p.cdb.valid  = 1'b1;
        p.cdb.dest   = 6'(d);
        p.cdb.result = 32'(r);
        return p;
    endfunction

    function automatic reg_wb_t mkreg(input rob_wb_t p);
        reg_wb_t w;
        w.cdb = p.cdb;
        w.w_v = p.cdb.valid;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) fu_pkt[i] = '0;
    endtask

    task automatic expect_out(input string tag, input rob_wb_t p);
        chk(tag, 64'(rob_wb), 64'(p));
        chk({tag, "_reg"}, 64'(reg_wb), 64'(mkreg(p)));
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        clr();

        // Reset state
        #2;
        expect_out("reset_out", rob_wb_t'('0));
        chk("reset_stall", 64'(stall), 64'(4'b0000));
        chk("reset_ovf", 64'(ovf), 64'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single packet from FU2, 2-cycle latency, one-cycle valid pulse
        fu_pkt[2] = mk(5, 9, 'h00F0);
        tick(); clr();
        expect_out("single_early", rob_wb_t'('0));
        tick();
        expect_out("single", mk(5, 9, 'h00F0));
        tick();
        expect_out("single_after", rob_wb_t'('0));

        // Flush to bring rr_ptr back to 0
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Contention: all four push together, drained 0,1,2,3
        for (int i = 0; i < N; i++) fu_pkt[i] = mk(i, 10 + i, 'h100 + i);
        tick(); clr();
        tick();
        for (int i = 0; i < N; i++) begin
            expect_out($sformatf("cont_%0d", i), mk(i, 10 + i, 'h100 + i));
            tick();
        end
        expect_out("cont_idle", rob_wb_t'('0));
        // rr_ptr back at 0: FU0 must beat FU1
        fu_pkt[0] = mk(6, 1, 'h6);
        fu_pkt[1] = mk(7, 2, 'h7);
        tick(); clr();
        tick();
        expect_out("ptr0_first", mk(6, 1, 'h6));
        tick();
        expect_out("ptr0_second", mk(7, 2, 'h7));

        // Fairness: FU0 streams, FU3 pushes once (rr_ptr now 2)
        fu_pkt[0] = mk(1, 1, 1);
        tick();
        fu_pkt[0] = mk(2, 1, 2);
        fu_pkt[3] = mk(31, 3, 'h31);
        tick();
        fu_pkt[0] = mk(3, 1, 3);
        fu_pkt[3] = '0;
        expect_out("fair_c2", mk(1, 1, 1));
        tick();
        fu_pkt[0] = mk(4, 1, 4);
        expect_out("fair_c3_fu3", mk(31, 3, 'h31));
        tick();
        fu_pkt[0] = mk(5, 1, 5);
        expect_out("fair_c4", mk(2, 1, 2));
        tick(); clr();
        expect_out("fair_c5", mk(3, 1, 3));
        tick();
        expect_out("fair_c6", mk(4, 1, 4));
        tick();
        expect_out("fair_c7", mk(5, 1, 5));

        // Stall / skid / overflow: all FUs push every cycle from empty
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: chk("stall_s0", 64'(stall), 64'(4'b0000));
                1: chk("stall_s1", 64'(stall), 64'(4'b0000));
                2: chk("stall_s2", 64'(stall), 64'(4'b1110));
                default: chk($sformatf("stall_s%0d", s), 64'(stall), 64'(4'b1111));
            endcase
            chk($sformatf("ovf_s%0d", s), 64'(ovf), 64'(1'b0));
            if (s >= 2) expect_out($sformatf("skid_out_s%0d", s), mk((s - 2) * 8, s - 2, 0));
            for (int f = 0; f < N; f++) fu_pkt[f] = mk(f * 8 + s, f, s);
            tick();
        end
        // s5: all full; FU0 push coincides with its pop, so it is accepted
        clr();
        fu_pkt[0] = mk(5, 0, 5);
        chk("ovf_s5", 64'(ovf), 64'(1'b0));
        chk("stall_s5", 64'(stall), 64'(4'b1111));
        expect_out("skid_out_s5", mk(24, 3, 0));
        tick(); clr();
        // s6: FU3 full and not granted, so its push is dropped
        fu_pkt[3] = mk(30, 3, 6);
        chk("ovf_s6", 64'(ovf), 64'(1'b0));
        expect_out("skid_out_s6", mk(1, 0, 1));
        tick(); clr();
        chk("ovf_s7", 64'(ovf), 64'(1'b1));
        expect_out("skid_out_s7", mk(9, 1, 1));

        // Flush with full FIFOs; the flush-cycle push must vanish
        flush = 1'b1;
        fu_pkt[2] = mk(17, 2, 'hDEAD);
        tick();
        flush = 1'b0;
        clr();
        expect_out("flush_out", rob_wb_t'('0));
        chk("flush_stall", 64'(stall), 64'(4'b0000));
        chk("flush_ovf_sticky", 64'(ovf), 64'(1'b1));
        fu_pkt[1] = mk(20, 3, 'hABCD);
        tick(); clr();
        expect_out("flush_f2", rob_wb_t'('0));
        tick();
        expect_out("flush_f3", mk(20, 3, 'hABCD));
        tick();
        expect_out("flush_f4", rob_wb_t'('0));

        // Async reset mid-drain (rr_ptr now 2, so FU2 wins first)
        for (int i = 0; i < N; i++) fu_pkt[i] = mk(12 + i, i, 'h50 + i);
        tick(); clr();
        tick();
        expect_out("rst_pre", mk(14, 2, 'h52));
        #3;
        reset = 1'b1;
        #1;
        expect_out("rst_async_out", rob_wb_t'('0));
        chk("rst_async_stall", 64'(stall), 64'(4'b0000));
        chk("rst_async_ovf", 64'(ovf), 64'(1'b0));
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("rst_post_%0d", i), rob_wb_t'('0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
